pll_lock_supervisor: RTL and testbench

//  Controls the PLL's RESET input and monitors its LOCK output, so the PLL wrapper is consumed from the other side.

---
 rtl/pll_sup_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 18 +
 rtl/pll_lock_supervisor.sv | 159 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PRST = 3'd0,
    WAIT = 3'd1,
    STAB = 3'd2,
    RUN  = 3'd3,
    FAIL = 3'd4
  } state_t;

  localparam int RETRY_W = 8;

  // One counter serves every state, so it must hold the largest reload value.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL RESET, qualifies LOCK and gates the downstream reset; retries and gives up after MAX_RETRY.
// Optional macro PLL_SUP_STATUS_EN adds loss_cnt / state_dbg status ports.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               sys_rst_n,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SUP_STATUS_EN
  ,
  output logic [15:0]        loss_cnt,
  output logic [2:0]         state_dbg
`endif
);

  localparam int CW = cnt_width(int'(RST_CYCLES), int'(LOCK_TIMEOUT),
                                int'(STABLE_CYCLES), int'(LOSS_FILTER));

  localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LF_LD  = CW'(LOSS_FILTER - 1);
  // The WAIT->STAB edge already consumed one locked sample of the window.
  localparam logic [CW-1:0] STB_LD = (STABLE_CYCLES >= 2) ? CW'(STABLE_CYCLES - 2) : '0;

  logic               lock_s;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fail_q, fail_d;
  logic               pll_reset_q, pll_reset_d;
  logic               run_q, run_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    case (state_q)
      PRST: begin
        if (cnt_q == '0) begin
          state_d = WAIT;
          cnt_d   = TO_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT: begin
        if (lock_s) begin
          if (STABLE_CYCLES <= 1) begin
            state_d = RUN;
            cnt_d   = LF_LD;
          end else begin
            state_d = STAB;
            cnt_d   = STB_LD;
          end
        end else if (cnt_q == '0) begin
          if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
          if (MAX_RETRY != 0 && (32'(retry_q) + 32'd1) >= MAX_RETRY) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = PRST;
            cnt_d   = RST_LD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STAB: begin
        if (!lock_s) begin
          state_d = WAIT;
          cnt_d   = TO_LD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = LF_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RUN: begin
        // In RUN the counter is the loss filter; any locked sample re-arms it.
        if (lock_s) begin
          cnt_d = LF_LD;
        end else if (cnt_q == '0) begin
          state_d = PRST;
          cnt_d   = RST_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FAIL: ;
      default: begin
        state_d = PRST;
        cnt_d   = RST_LD;
      end
    endcase
  end

  assign pll_reset_d = (state_d == PRST) || (state_d == FAIL);
  assign run_d       = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRST;
      cnt_q       <= RST_LD;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      pll_reset_q <= pll_reset_d;
      run_q       <= run_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = run_q;
  assign locked    = run_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

`ifdef PLL_SUP_STATUS_EN
  logic [15:0] loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (state_q == RUN && state_d == PRST && loss_q != '1) begin
      loss_q <= loss_q + 16'd1;
    end
  end

  assign loss_cnt  = loss_q;
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset, sys_rst_n, locked, fail;
  logic [7:0] retry_cnt;
`ifdef PLL_SUP_STATUS_EN
  logic [15:0] loss_cnt;
  logic [2:0]  state_dbg;
`endif

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (16),
    .LOSS_FILTER   (3),
    .MAX_RETRY     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef PLL_SUP_STATUS_EN
    ,
    .loss_cnt  (loss_cnt),
    .state_dbg (state_dbg)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Counts posedges until the selected output reaches val (sampled 1 ns after each edge).
  task automatic wait_sig(input int sel, input logic val, input int bound, output int cnt);
    logic cur;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      case (sel)
        0:       cur = pll_reset;
        1:       cur = sys_rst_n;
        default: cur = fail;
      endcase
    end while (cur !== val && cnt < bound);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    #1;
    chk({tag, "_rst_pll_reset"}, 32'(pll_reset), 1);
    chk({tag, "_rst_sys_rst_n"}, 32'(sys_rst_n), 0);
    chk({tag, "_rst_locked"},    32'(locked),    0);
    chk({tag, "_rst_fail"},      32'(fail),      0);
    chk({tag, "_rst_retry"},     32'(retry_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;

    // Test 2: lock never arrives -> two attempts, then FAIL.
    apply_reset("t2");
    wait_sig(0, 1'b0, 50, n);  chk("t2_prst1_len", n, 4);
    wait_sig(0, 1'b1, 200, n); chk("t2_wait1_len", n, 100);
    chk("t2_retry1", 32'(retry_cnt), 1);
    chk("t2_fail_early", 32'(fail), 0);
    wait_sig(0, 1'b0, 50, n);  chk("t2_prst2_len", n, 4);
    wait_sig(2, 1'b1, 200, n); chk("t2_wait2_len", n, 100);
    chk("t2_retry2", 32'(retry_cnt), 2);
    chk("t2_pll_reset", 32'(pll_reset), 1);
    chk("t2_sys_rst_n", 32'(sys_rst_n), 0);
    step(30);
    chk("t2_fail_sticky", 32'(fail), 1);
    chk("t2_pll_reset_held", 32'(pll_reset), 1);
    chk("t2_retry_held", 32'(retry_cnt), 2);

    // Test 1: lock 10 cycles after pll_reset falls -> sys_rst_n at +29.
    apply_reset("t1");
    wait_sig(0, 1'b0, 50, n); chk("t1_prst_len", n, 4);
    step(10);
    pll_lock = 1'b1;
    wait_sig(1, 1'b1, 100, n); chk("t1_release_lat", 10 + n, 29);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_retry", 32'(retry_cnt), 0);
    chk("t1_pll_reset", 32'(pll_reset), 0);

    // Test 3: 2-cycle glitch ignored; 3-cycle loss re-arms, twice.
    pll_lock = 1'b0;
    step(2);
    pll_lock = 1'b1;
    begin
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step(1);
        if (sys_rst_n !== 1'b1 || pll_reset !== 1'b0) ok = 1'b0;
      end
      chk("t3_glitch_ignored", 32'(ok), 1);
    end
    for (int k = 0; k < 2; k++) begin
      pll_lock = 1'b0;
      step(3);
      pll_lock = 1'b1;
      chk("t3_still_run", 32'(sys_rst_n), 1);
      wait_sig(1, 1'b0, 20, n); chk("t3_loss_lat", 3 + n, 5);
      chk("t3_pll_reset", 32'(pll_reset), 1);
      chk("t3_locked", 32'(locked), 0);
      chk("t3_retry", 32'(retry_cnt), 0);
      wait_sig(1, 1'b1, 100, n); chk("t3_relock_lat", n, 21);
    end
`ifdef PLL_SUP_STATUS_EN
    chk("t6_loss_cnt", 32'(loss_cnt), 2);
    chk("t6_state_dbg", 32'(state_dbg), 3);
`endif

    // Test 4: lock drops once in STAB -> back to WAIT, full window again.
    apply_reset("t4");
    wait_sig(0, 1'b0, 50, n); chk("t4_prst_len", n, 4);
    step(10);
    pll_lock = 1'b1;
    step(8);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    chk("t4_not_run", 32'(sys_rst_n), 0);
    wait_sig(1, 1'b1, 100, n); chk("t4_release_lat", 19 + n, 38);
    chk("t4_retry", 32'(retry_cnt), 0);

    // Test 5: asynchronous reset while in RUN.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_pll_reset", 32'(pll_reset), 1);
    chk("t5_sys_rst_n", 32'(sys_rst_n), 0);
    chk("t5_locked", 32'(locked), 0);
    chk("t5_fail", 32'(fail), 0);
    chk("t5_retry", 32'(retry_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 1'b0, 50, n); chk("t5_prst_len", n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
